// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, ROM address drive and IF/ID pipeline register.
// Build option IF_DELAY_SLOT_EN: a taken branch captures the delay-slot word instead of a bubble.
module if_stage #(
  parameter int                 ADDR_W   = 8,
  parameter int                 INSTR_W  = 32,
  parameter int                 PC_STEP  = 4,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
  input  logic               clk,
  input  logic               R,
  input  logic               LE,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [INSTR_W-1:0] rom_instruction,
  output logic [ADDR_W-1:0]  rom_address,
  output logic [ADDR_W-1:0]  pc_plus_step,
  output logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  id_pc,
  output logic               id_valid,
  output logic [15:0]        fetch_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [ADDR_W-1:0]    r_pc;
  logic [ADDR_W-1:0]    w_pc_next;
  logic [INSTR_W-1:0]   r_instr;
  logic [INSTR_W-1:0]   w_instr_next;
  logic [ADDR_W-1:0]    r_id_pc;
  logic [ADDR_W-1:0]    w_id_pc_next;
  logic                 r_id_valid;
  logic                 w_id_valid_next;
  logic [15:0]          r_fetch_count;
  logic [15:0]          w_fetch_count_next;
  logic [15:0]          w_fetch_count_inc;
  logic [ADDR_W-1:0]    w_pc_plus_step;

  assign w_pc_plus_step    = r_pc + ADDR_W'(PC_STEP);
  assign w_fetch_count_inc = (r_fetch_count == 16'hFFFF) ? r_fetch_count : r_fetch_count + 16'd1;

  always_ff @(posedge clk) begin
    if (R) begin
      r_state       <= BOOT;
      r_pc          <= '0;
      r_instr       <= NOP_WORD;
      r_id_pc       <= '0;
      r_id_valid    <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_instr       <= w_instr_next;
      r_id_pc       <= w_id_pc_next;
      r_id_valid    <= w_id_valid_next;
      r_fetch_count <= w_fetch_count_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_instr_next       = r_instr;
    w_id_pc_next       = r_id_pc;
    w_id_valid_next    = r_id_valid;
    w_fetch_count_next = r_fetch_count;

    case (r_state)
      BOOT:    w_state_next = RUN;
`ifdef IF_DELAY_SLOT_EN
      RUN:     w_state_next = RUN;
`else
      RUN:     w_state_next = branch_taken ? FLUSH : RUN;
`endif
      FLUSH:   w_state_next = branch_taken ? FLUSH : RUN;
      default: w_state_next = BOOT;
    endcase

    // Redirect beats the stall: the target must be taken even while LE is low.
    if (branch_taken) begin
      w_pc_next          = branch_target;
`ifdef IF_DELAY_SLOT_EN
      w_instr_next       = rom_instruction;
      w_id_pc_next       = r_pc;
      w_id_valid_next    = 1'b1;
      w_fetch_count_next = w_fetch_count_inc;
`else
      w_instr_next       = NOP_WORD;
      w_id_pc_next       = '0;
      w_id_valid_next    = 1'b0;
`endif
    end else if (LE) begin
      w_pc_next          = w_pc_plus_step;
      w_instr_next       = rom_instruction;
      w_id_pc_next       = r_pc;
      w_id_valid_next    = 1'b1;
      w_fetch_count_next = w_fetch_count_inc;
    end
  end

  assign rom_address  = r_pc;
  assign pc_plus_step = w_pc_plus_step;
  assign Instruction  = r_instr;
  assign id_pc        = r_id_pc;
  assign id_valid     = r_id_valid;
  assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vectors, a spec-level fetch model checked every cycle,
// and literal expectations at the test-plan checkpoints.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        R = 1'b1;
  logic        LE = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic [31:0] rom_instruction;
  logic [7:0]  rom_address;
  logic [7:0]  pc_plus_step;
  logic [31:0] Instruction;
  logic [7:0]  id_pc;
  logic        id_valid;
  logic [15:0] fetch_count;

  int n_vec = 0;
  int n_bad = 0;
  int n_step = 0;
  bit verbose = 1'b1;

  // Spec-level model state
  bit m_known = 1'b0;
  int m_pc, m_id_pc, m_cnt;
  int unsigned m_instr;
  bit m_valid;

  if_stage dut (
    .clk(clk), .R(R), .LE(LE), .branch_taken(branch_taken), .branch_target(branch_target),
    .rom_instruction(rom_instruction), .rom_address(rom_address), .pc_plus_step(pc_plus_step),
    .Instruction(Instruction), .id_pc(id_pc), .id_valid(id_valid), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // ROM contents: word k holds E000_0000 + k
  function automatic int unsigned rom_word(int addr);
    return 32'hE000_0000 + addr / 4;
  endfunction

  assign rom_instruction = rom_word(int'(rom_address));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, n_step, act, exp);
    end
  endtask

  // Model: what IF/ID and PC must hold after each edge.
  always @(posedge clk) begin
    if (R) begin
      m_pc = 0; m_instr = 0; m_id_pc = 0; m_valid = 0; m_cnt = 0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (branch_taken) begin
`ifdef IF_DELAY_SLOT_EN
        m_instr = rom_word(m_pc); m_id_pc = m_pc; m_valid = 1;
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
`else
        m_instr = 0; m_id_pc = 0; m_valid = 0;
`endif
        m_pc = int'(branch_target);
      end else if (LE) begin
        m_instr = rom_word(m_pc); m_id_pc = m_pc; m_valid = 1;
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        m_pc = (m_pc + 4) % 256;
      end
    end
  end

  // Compare process: checks every output against the model on each falling edge.
  always @(negedge clk) begin
    if (m_known) begin
      chk("rom_address", 32'(rom_address), 32'(m_pc));
      chk("pc_plus_step", 32'(pc_plus_step), 32'((m_pc + 4) % 256));
      chk("Instruction", Instruction, m_instr);
      chk("id_pc", 32'(id_pc), 32'(m_id_pc));
      chk("id_valid", 32'(id_valid), 32'(m_valid));
      chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
    end
  end

  task automatic step(input logic r, input logic le, input logic bt, input logic [7:0] tgt);
    R = r; LE = le; branch_taken = bt; branch_target = tgt;
    @(posedge clk);
    @(negedge clk);
    #1;
    n_step++;
    if (verbose)
      $display("step %0d R=%b LE=%b bt=%b tgt=%h -> pc=%h instr=%h id_pc=%h valid=%b cnt=%0d",
               n_step, r, le, bt, tgt, rom_address, Instruction, id_pc, id_valid, fetch_count);
  endtask

  initial begin
    #1;
    // Reset, then free-run four fetches
    step(1, 0, 0, 8'h00); step(1, 1, 1, 8'h40);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_valid", 32'(id_valid), 32'h0);
    chk("rst_cnt", 32'(fetch_count), 32'h0);
    chk("rst_pc", 32'(rom_address), 32'h0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00);
    chk("run_id_pc", 32'(id_pc), 32'h0C);
    chk("run_cnt", 32'(fetch_count), 32'd4);
    chk("run_pc", 32'(rom_address), 32'h10);
    chk("run_instr", Instruction, 32'hE000_0003);

    // Stall at PC=8
    step(1, 0, 0, 8'h00); step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00); step(0, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00);
    chk("stall_pc", 32'(rom_address), 32'h08);
    chk("stall_id_pc", 32'(id_pc), 32'h04);
    chk("stall_instr", Instruction, 32'hE000_0001);
    chk("stall_cnt", 32'(fetch_count), 32'd2);
    step(0, 1, 0, 8'h00);
    chk("resume_id_pc", 32'(id_pc), 32'h08);
    chk("resume_instr", Instruction, 32'hE000_0002);

    // Redirect to 0x40 from PC=12
    step(0, 1, 1, 8'h40);
    chk("redir_pc", 32'(rom_address), 32'h40);
`ifdef IF_DELAY_SLOT_EN
    chk("redir_instr", Instruction, 32'hE000_0003);
    chk("redir_valid", 32'(id_valid), 32'h1);
    chk("redir_cnt", 32'(fetch_count), 32'd4);
`else
    chk("redir_instr", Instruction, 32'h0);
    chk("redir_valid", 32'(id_valid), 32'h0);
    chk("redir_cnt", 32'(fetch_count), 32'd3);
`endif
    step(0, 1, 0, 8'h00);
    chk("target_id_pc", 32'(id_pc), 32'h40);
    chk("target_valid", 32'(id_valid), 32'h1);
    chk("target_instr", Instruction, 32'hE000_0010);

    // Branch while stalled, then back-to-back branches
    step(0, 0, 1, 8'h20);
    chk("bstall_pc", 32'(rom_address), 32'h20);
`ifdef IF_DELAY_SLOT_EN
    chk("bstall_valid", 32'(id_valid), 32'h1);
    chk("bstall_id_pc", 32'(id_pc), 32'h44);
`else
    chk("bstall_valid", 32'(id_valid), 32'h0);
`endif
    step(0, 1, 1, 8'h30);
    chk("b2b_pc", 32'(rom_address), 32'h30);

    // Wrap at 0xFC
    step(0, 1, 1, 8'hFC);
    chk("wrap_step", 32'(pc_plus_step), 32'h00);
    step(0, 1, 0, 8'h00);
    chk("wrap_id_pc", 32'(id_pc), 32'hFC);
    chk("wrap_pc", 32'(rom_address), 32'h00);

    // Unaligned target passes through
    step(0, 1, 1, 8'h13);
    chk("unal_step", 32'(pc_plus_step), 32'h17);
    step(0, 1, 0, 8'h00);
    chk("unal_id_pc", 32'(id_pc), 32'h13);
    chk("unal_instr", Instruction, 32'hE000_0004);

    // Reset in FLUSH with a redirect pending
    step(0, 1, 1, 8'h50);
    step(1, 1, 1, 8'h60);
    chk("mrst_pc", 32'(rom_address), 32'h0);
    chk("mrst_valid", 32'(id_valid), 32'h0);
    chk("mrst_cnt", 32'(fetch_count), 32'h0);
    step(0, 1, 0, 8'h00);
    chk("post_id_pc", 32'(id_pc), 32'h0);
    chk("post_valid", 32'(id_valid), 32'h1);
    chk("post_cnt", 32'(fetch_count), 32'd1);

    // Reset during a stall
    step(0, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    chk("srst_pc", 32'(rom_address), 32'h0);
    chk("srst_cnt", 32'(fetch_count), 32'h0);

    // fetch_count saturation
    verbose = 1'b0;
    for (int i = 0; i < 65535; i++) step(0, 1, 0, 8'h00);
    chk("sat_max", 32'(fetch_count), 32'hFFFF);
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    verbose = 1'b1;
    chk("sat_hold", 32'(fetch_count), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline: owns the PC register, the PC increment, the ROM address drive and the IF/ID pipeline register.
- Feeds the decode stage (Control_Unit input) with a registered instruction word plus its PC and a valid bit.
- Accepts a stall from the hazard logic and a taken-branch redirect (B/BL resolved in ID).
- Inserts flush bubbles on redirect.

Parameters:
- ADDR_W, 8, width of PC and ROM address.
- INSTR_W, 32, instruction word width.
- PC_STEP, 4, PC increment per fetched instruction, in bytes.
- NOP_WORD, 32'h0000_0000, word loaded into IF/ID on flush or reset.

Ports:
- clk  in  1  pipeline clock, rising edge.
- R  in  1  reset, synchronous, active-high.
- LE  in  1  load enable from hazard unit; 0 = stall (hold PC and IF/ID).
- branch_taken  in  1  ID-stage taken B/BL; redirect request.
- branch_target  in  ADDR_W  redirect address, byte address.
- rom_instruction  in  INSTR_W  combinational ROM read data for rom_address.
- rom_address  out  ADDR_W  equals current PC (combinational from PC register).
- pc_plus_step  out  ADDR_W  PC + PC_STEP, modulo 2^ADDR_W (link value for BL).
- Instruction  out  INSTR_W  IF/ID registered instruction.
- id_pc  out  ADDR_W  PC of the instruction in IF/ID.
- id_valid  out  1  1 = Instruction is a real fetch; 0 = bubble.
- fetch_count  out  16  number of valid instructions delivered to ID since reset, saturating.

Behaviour:
- Reset (R=1 at rising edge): PC=0, Instruction=NOP_WORD, id_pc=0, id_valid=0, fetch_count=0, state=BOOT. R dominates all other inputs.
- States:
  - BOOT: first cycle after reset release; fetch from PC=0.
  - RUN: normal fetch.
  - FLUSH: one-cycle bubble after a redirect.
  - Transitions:
    - BOOT->RUN unconditionally on the next edge, capturing as in RUN.
    - RUN->FLUSH on an edge with branch_taken=1.
    - FLUSH->RUN on the next edge, or FLUSH->FLUSH if branch_taken is again 1.
- Per rising edge, R=0, evaluated in priority order:
  - branch_taken=1 (overrides LE): PC<=branch_target; Instruction<=NOP_WORD, id_valid<=0, id_pc<=0 (default build).
  - LE=0: PC, Instruction, id_pc, id_valid and fetch_count all hold.
  - Otherwise: Instruction<=rom_instruction, id_pc<=PC, id_valid<=1, PC<=PC+PC_STEP.
- In FLUSH with LE=1 and no branch: fetch normally from the redirected PC. The bubble is already in IF/ID.
- Latency: the instruction at address A appears on Instruction one edge after PC=A. A redirect issued at edge n yields the target instruction in IF/ID at edge n+1 (n+2 in ID terms, one bubble).
- PC arithmetic is unsigned ADDR_W-bit and wraps: 8'hFC+4 -> 8'h00. branch_target is not aligned or checked; low bits pass through.
- fetch_count increments on each edge that loads id_valid<=1 and saturates at 16'hFFFF.
- R asserted mid-stall or mid-FLUSH returns to BOOT with reset values; any pending redirect is discarded.
- No X-propagation: all outputs have defined values from the first edge with R=1.

Optional Feature:
- Macro IF_DELAY_SLOT_EN.
- Defined:
  - A taken branch does not flush. The word being fetched at the redirect edge (the delay slot) is captured normally with id_valid=1, and fetch_count increments.
  - PC<=branch_target as usual.
  - The FLUSH state is not entered: the FSM goes RUN->RUN.
  - If branch_taken and LE=0 coincide, the redirect is still taken and the slot is captured.
- Undefined: flush behaviour as in Behaviour (one bubble per redirect).

Test Plan:
- Reset then free-run: R=1 for 2 edges, R=0, LE=1, ROM[k]=32'hE000_0000+k → after edges 1..4, id_pc=0,4,8,12 and id_valid=1; fetch_count=4; rom_address=16.
- Stall: LE=0 for 3 edges while PC=8 → PC stays 8, Instruction/id_pc hold the word from PC=4, fetch_count is unchanged; on LE=1 the next edge loads the word from PC=8.
- Redirect: branch_taken=1 and branch_target=8'h40 at PC=8 → next edge Instruction=NOP_WORD, id_valid=0, PC=8'h40; following edge id_pc=8'h40, id_valid=1.
- Branch during stall: LE=0 with branch_taken=1 and target 8'h20 → PC=8'h20 and a bubble is inserted (default); with IF_DELAY_SLOT_EN, the slot word is captured with id_valid=1.
- Wrap: PC=8'hFC with LE=1 → id_pc=8'hFC; PC=8'h00; pc_plus_step read at PC=8'hFC equals 8'h00.
- Mid-operation reset: R=1 while in FLUSH → next edge PC=0, id_valid=0, fetch_count=0, state=BOOT; the first post-reset fetch has id_pc=0.
